// File: rtl/othello_pkg.sv
// Shared Othello definitions: key indices, key count and auto-repeat phases.
package othello_pkg;

    localparam int N_KEYS    = 5;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_PLACE = 4;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_phase_e;

endpackage

// File: rtl/othello_key_scheduler_if.sv
// Command handshake between the key scheduler and the game controller.
interface othello_key_scheduler_if #(
    parameter int ID_W = $clog2(othello_pkg::N_KEYS)
) ();

    logic            cmd_valid;
    logic [ID_W-1:0] cmd_id;
    logic            cmd_repeat;
    logic            cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_id,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        input  cmd_repeat,
        output cmd_ready
    );

endinterface

// File: rtl/othello_key_scheduler_key_event_gen.sv
// Per-key event generator: rising-edge press plus optional hold/repeat events.
// Latency: combinational event in the cycle the condition is seen.
// Backpressure: none; events are always produced and queued downstream.
module key_event_gen
    import othello_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 25,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic key,
    output logic evt_vld,
    output logic is_repeat
);

    logic             prev;
    logic [CNT_W-1:0] cnt;
    rpt_phase_e       phase;

    logic press;
    logic hold_hit;
    logic rpt_hit;

    assign press    = key & ~prev;
    assign hold_hit = (phase == RPT_HOLD)   && (cnt == CNT_W'(HOLD_CYCLES - 1));
    assign rpt_hit  = (phase == RPT_REPEAT) && (cnt == CNT_W'(REPEAT_CYCLES - 1));

    // A non-idle phase implies the key was already high, so a repeat never coincides with a press.
    assign is_repeat = key & (hold_hit | rpt_hit);
    assign evt_vld   = press | is_repeat;

    // prev resets to 1 so a key held through reset must be released before it counts.
    always_ff @(posedge clock) begin
        if (resetn) begin
            prev  <= 1'b1;
            cnt   <= '0;
            phase <= RPT_IDLE;
        end else begin
            prev <= key;
            if (!key || press) begin
                cnt   <= '0;
                phase <= (press && REPEAT_EN) ? RPT_HOLD : RPT_IDLE;
            end else if (phase != RPT_IDLE) begin
                if (hold_hit || rpt_hit) begin
                    cnt   <= '0;
                    phase <= RPT_REPEAT;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/othello_key_scheduler.sv
// Turns key levels into queued press/repeat commands served round-robin.
// Latency: key rise to cmd_valid is 2 cycles when the output register is empty.
// Backpressure: cmd_ready low holds the command; new events coalesce per key (dropped pulses).
module othello_key_scheduler #(
    parameter int                 N_KEYS        = othello_pkg::N_KEYS,
    parameter int                 HOLD_CYCLES   = 25000000,
    parameter int                 REPEAT_CYCLES = 10000000,
    parameter int                 CNT_W         = 25,
    parameter logic [N_KEYS-1:0]  REPEAT_MASK   = 5'b01111
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [N_KEYS-1:0]    key,
    othello_key_scheduler_if.master cmd,
    output logic                 dropped,
    output logic [N_KEYS-1:0]    pending
);

    localparam int ID_W = $clog2(N_KEYS);

    logic [N_KEYS-1:0] evt;
    logic [N_KEYS-1:0] evt_rep;
    logic [N_KEYS-1:0] rep_q;
    logic [N_KEYS-1:0] rep_nxt;
    logic [N_KEYS-1:0] clr;
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   sel;
    logic              found;
    logic              load;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_event_gen #(
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W),
            .REPEAT_EN     (REPEAT_MASK[g])
        ) u_gen (
            .clock     (clock),
            .resetn    (resetn),
            .key       (key[g]),
            .evt_vld   (evt[g]),
            .is_repeat (evt_rep[g])
        );
    end

    // Walk from the pointer downwards in priority so the nearest pending index at/after rr wins.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            idx = int'(rr) + k;
            if (idx >= N_KEYS) idx = idx - N_KEYS;
            if (pending[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    assign load = ~cmd.cmd_valid | cmd.cmd_ready;
    assign clr  = (load && found) ? ({{(N_KEYS-1){1'b0}}, 1'b1} << sel) : '0;

    // A press always forces the flag to 0; a repeat only marks a slot that is free this cycle.
    always_comb begin
        rep_nxt = rep_q;
        for (int i = 0; i < N_KEYS; i++) begin
            if (evt[i] && !evt_rep[i])
                rep_nxt[i] = 1'b0;
            else if (evt[i] && !(pending[i] && !clr[i]))
                rep_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            pending        <= '0;
            rep_q          <= '0;
            rr             <= '0;
            dropped        <= 1'b0;
            cmd.cmd_valid  <= 1'b0;
            cmd.cmd_id     <= '0;
            cmd.cmd_repeat <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | evt;
            rep_q   <= rep_nxt;
            dropped <= |(evt & pending & ~clr);
            if (load) begin
                cmd.cmd_valid <= found;
                if (found) begin
                    cmd.cmd_id     <= sel;
                    cmd.cmd_repeat <= rep_q[sel];
                    rr             <= (sel == ID_W'(N_KEYS - 1)) ? '0 : sel + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_othello_key_scheduler.sv
// Scoreboard bench: an age-based key model predicts per-cycle status and the accepted command stream.
module tb_othello_key_scheduler;

    localparam int NK   = 5;
    localparam int HOLD = 4;
    localparam int REP  = 2;
    localparam logic [NK-1:0] MASK = 5'b01111;

    typedef struct {
        bit v;
        int id;
        bit r;
        int pend;
        bit d;
    } st_t;

    typedef struct {
        int id;
        bit r;
    } cmd_t;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic [NK-1:0] key = '0;
    logic          dropped;
    logic [NK-1:0] pending;

    int vectors = 0;
    int miscompares = 0;

    othello_key_scheduler_if #(.ID_W(3)) ifc ();

    othello_key_scheduler #(
        .N_KEYS        (NK),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (25),
        .REPEAT_MASK   (MASK)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .key     (key),
        .cmd     (ifc),
        .dropped (dropped),
        .pending (pending)
    );

    always #5 clock = ~clock;

    // Reference model state: age = cycles since the rise (-1 when not tracking).
    int   age [NK];
    bit   mprev [NK];
    bit   mpend [NK];
    bit   mrep [NK];
    bit   mvalid;
    int   mid;
    bit   mcrep;
    int   mrr;
    bit   mdrop;
    st_t  st_q [$];
    cmd_t cmd_q [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pend_word();
        int w = 0;
        for (int i = 0; i < NK; i++) if (mpend[i]) w |= (1 << i);
        return w;
    endfunction

    task automatic model_step();
        st_t s;
        bit  ev [NK];
        bit  evr [NK];
        int  clr_id;
        bit  found;
        int  sel;
        clr_id = -1;
        found  = 0;
        sel    = 0;
        if (resetn) begin
            for (int i = 0; i < NK; i++) begin
                age[i] = -1; mprev[i] = 1; mpend[i] = 0; mrep[i] = 0;
            end
            mvalid = 0; mid = 0; mcrep = 0; mrr = 0; mdrop = 0;
            cmd_q.delete();
        end else begin
            for (int i = 0; i < NK; i++) begin
                bit press;
                press = key[i] && !mprev[i];
                if (press) age[i] = 0;
                else if (key[i] && age[i] >= 0) age[i]++;
                else if (!key[i]) age[i] = -1;
                ev[i]  = press || (MASK[i] && age[i] >= HOLD && ((age[i] - HOLD) % REP) == 0);
                evr[i] = ev[i] && !press;
                mprev[i] = key[i];
            end
            if (!mvalid || ifc.cmd_ready) begin
                for (int k = 0; k < NK; k++) begin
                    int idx;
                    idx = (mrr + k) % NK;
                    if (!found && mpend[idx]) begin
                        found = 1;
                        sel = idx;
                    end
                end
                mvalid = found;
                if (found) begin
                    clr_id = sel;
                    mid    = sel;
                    mcrep  = mrep[sel];
                    mrr    = (sel + 1) % NK;
                    cmd_q.push_back('{id: sel, r: mrep[sel]});
                end
            end
            mdrop = 0;
            for (int i = 0; i < NK; i++) begin
                bit busy;
                busy = mpend[i] && (clr_id != i);
                if (ev[i] && busy) mdrop = 1;
                if (ev[i] && !evr[i]) mrep[i] = 0;
                else if (ev[i] && !busy) mrep[i] = 1;
                mpend[i] = busy || ev[i];
            end
        end
        s.v = mvalid; s.id = mid; s.r = mcrep; s.pend = pend_word(); s.d = mdrop;
        st_q.push_back(s);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            model_step();
            #1;
        end
    endtask

    // Monitor: compares the DUT against the model each cycle and on every accepted command.
    initial begin
        st_t  s;
        cmd_t c;
        forever begin
            @(negedge clock);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("cmd_valid", 32'(ifc.cmd_valid), 32'(s.v));
                check("pending", 32'(pending), 32'(s.pend));
                check("dropped", 32'(dropped), 32'(s.d));
                if (s.v) begin
                    check("cmd_id_status", 32'(ifc.cmd_id), 32'(s.id));
                    check("cmd_repeat_status", 32'(ifc.cmd_repeat), 32'(s.r));
                end
            end
            if (ifc.cmd_valid === 1'b1 && ifc.cmd_ready === 1'b1 && resetn === 1'b0) begin
                if (cmd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL cmd_unexpected: got id %0d with nothing expected", ifc.cmd_id);
                end else begin
                    c = cmd_q.pop_front();
                    check("accepted_id", 32'(ifc.cmd_id), 32'(c.id));
                    check("accepted_repeat", 32'(ifc.cmd_repeat), 32'(c.r));
                end
            end
        end
    end

    initial begin
        ifc.cmd_ready = 1'b1;
        resetn = 1'b1;
        key = '0;
        tick(3);
        resetn = 1'b0;
        tick(2);

        // Single-cycle place pulse.
        key[4] = 1'b1; tick(1); key[4] = 1'b0; tick(6);

        // Held direction key repeats; held place key does not.
        key[0] = 1'b1; tick(12); key[0] = 1'b0; tick(10);
        key[4] = 1'b1; tick(12); key[4] = 1'b0; tick(6);

        // Move pointer to 2, then keys 1 and 3 together.
        key[1] = 1'b1; tick(1); key[1] = 1'b0; tick(5);
        key[1] = 1'b1; key[3] = 1'b1; tick(1); key = '0; tick(6);

        // Stalled consumer: coalescing on key 2 while the output holds key 4.
        ifc.cmd_ready = 1'b0;
        key[4] = 1'b1; tick(1); key[4] = 1'b0; tick(3);
        key[2] = 1'b1; tick(1); key[2] = 1'b0; tick(1);
        key[2] = 1'b1; tick(1); key[2] = 1'b0; tick(4);
        ifc.cmd_ready = 1'b1; tick(6);

        // Key held through reset.
        key[0] = 1'b1; tick(2);
        resetn = 1'b1; tick(3); resetn = 1'b0;
        tick(8); key[0] = 1'b0; tick(3);
        key[0] = 1'b1; tick(1); key[0] = 1'b0; tick(6);

        // Reset while a command is presented with two more pending.
        ifc.cmd_ready = 1'b0;
        key[0] = 1'b1; key[1] = 1'b1; key[2] = 1'b1; tick(1); key = '0; tick(4);
        resetn = 1'b1; tick(1); resetn = 1'b0;
        ifc.cmd_ready = 1'b1; tick(8);

        // Randomized key levels, ready and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NK; i++)
                if ($urandom_range(0, 9) == 0) key[i] = ~key[i];
            ifc.cmd_ready = ($urandom_range(0, 3) != 0);
            resetn = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        resetn = 1'b0;
        key = '0;
        ifc.cmd_ready = 1'b1;
        tick(20);
        @(negedge clock);
        check("leftover_expected_cmds", 32'(cmd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/othello_key_scheduler.md
Name: othello_key_scheduler

Overview:
- Converts raw level inputs from the board push-buttons and switches into single-cycle key events.
- Events are generated on rising edges; direction keys also auto-repeat while held.
- Pending events queue per key and are served round-robin to the game FSM as one command at a time, over a valid/ready handshake.
- Sits between the input synchronizers and the Othello game controller, replacing ad-hoc per-key one-shot instances.

Parameters:
- N_KEYS, 5: number of key inputs. Index 0-3 are up/down/left/right; index 4 is place.
- HOLD_CYCLES, 25000000: cycles a repeat-enabled key must stay high before its first repeat event (must be ≥2).
- REPEAT_CYCLES, 10000000: cycles between subsequent repeat events while the key stays held (must be ≥1).
- CNT_W, 25: width of the hold/repeat counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES).
- REPEAT_MASK, 5'b01111: bit i set means key i auto-repeats.

Ports:
- clock  input  1  system clock, all logic on its rising edge
- resetn  input  1  synchronous, active-high reset (the name is the codebase's; asserted high = reset)
- key  input  N_KEYS  synchronized key levels, 1 = pressed
- cmd_valid  output  1  a command is presented
- cmd_id  output  $clog2(N_KEYS)  index of the key being presented
- cmd_repeat  output  1  1 if the presented command came from auto-repeat, 0 if from a fresh press
- cmd_ready  input  1  consumer accepts the command this cycle
- dropped  output  1  one-cycle pulse when an event coalesces into an already-pending event
- pending  output  N_KEYS  current pending bits, for debug/LEDs

Behaviour:
- Reset (resetn=1 at a clock edge):
  - cmd_valid=0, cmd_id=0, cmd_repeat=0, dropped=0, pending=0.
  - All counters=0, round-robin pointer=0.
  - Previous-level registers are set to all ones, so a key held through reset produces no event until it is released and pressed again.
- Edge event: key[i]=1 and prev[i]=0 in a cycle → press event for key i in that cycle. prev is key delayed by one cycle.
- Repeat (REPEAT_MASK[i]=1), per-key counter:
  - Cleared whenever key[i]=0, and on the press cycle.
  - Increments each cycle while the key stays held.
  - On reaching HOLD_CYCLES-1: repeat event, counter reloads to 0, key enters REPEAT phase.
  - In REPEAT phase: repeat event each time the counter reaches REPEAT_CYCLES-1, then reloads to 0.
  - Release returns the key to IDLE phase.
  - Mask-0 keys never count and never repeat.
- Pending queue:
  - Any event sets pending[i] and records rep[i] (1 = repeat, 0 = press).
  - A press always overwrites rep to 0.
  - If pending[i] is already 1 and not being cleared in the same cycle: the event coalesces and dropped pulses for one cycle.
- Output register states:
  - EMPTY (cmd_valid=0).
  - HOLD (cmd_valid=1, cmd_id/cmd_repeat stable until accepted).
- Load condition: cmd_valid=0, or cmd_valid=1 with cmd_ready=1.
  - On load, pick the first pending index at or after the RR pointer, wrapping modulo N_KEYS.
  - Load cmd_id and cmd_repeat, clear that pending bit, set RR pointer to (id+1) mod N_KEYS.
  - If nothing is pending on a load, cmd_valid drops to 0.
- Back-to-back: accept and load in the same cycle is allowed, giving one command per cycle throughput.
- Set-over-clear: an event for key i in the cycle key i is loaded leaves pending[i]=1 and does not pulse dropped.
- Latency: key rises at edge t → press event at t → pending visible after edge t+1 → cmd_valid high after edge t+2 when the output register was EMPTY.
- cmd_ready while cmd_valid=0 is ignored.
- Reset mid-operation: the presented command and all pending events are discarded. No command is replayed after reset.

Decomposition:
- Shared package othello_pkg holds:
  - key index constants KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3, KEY_PLACE=4;
  - N_KEYS;
  - a repeat-phase enum {RPT_IDLE, RPT_HOLD, RPT_REPEAT}.
- Natural sub-module: key_event_gen, one instance per key. It contains the prev register, the counter and the phase, and outputs the event and is_repeat flags.
- The top level holds the pending/rep registers, the round-robin selector and the output register.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=2, cmd_ready=1 unless stated):
- Key 4 pulsed high for 1 cycle → exactly one command id=4, repeat=0, cmd_valid high for exactly 1 cycle, first seen 2 cycles after the rise.
- Key 0 held 12 cycles → one press command, then repeat=1 commands whose key events fall 4, 6, 8, 10 cycles after the rise. Nothing after release. Key 4 held 12 cycles gives one command only.
- Keys 1 and 3 rise together with RR pointer=2 → commands id=3 then id=1 on consecutive cycles, after which the RR pointer=2.
- cmd_ready=0; key 2 pressed, released, pressed again while pending → dropped pulses once. After ready, a single id=2 command is delivered. cmd_id stays stable while stalled.
- Key 0 held through reset (reset asserted 3 cycles) → no command until key 0 is released and re-pressed. pending=0 and cmd_valid=0 during and right after reset.
- Reset asserted while cmd_valid=1 with 2 pending → next cycle cmd_valid=0 and pending=0. No command appears afterwards without new presses.
